// File: rtl/divider_24bit.sv
// divider_24bit: sequential unsigned restoring divider.
// One quotient bit is produced per clock, MSB first. The quotient bits
// replace the dividend bits in the same shift register as the dividend is
// consumed. Divide-by-zero finishes in one cycle with Q = all ones, R = A.
module divider_24bit #(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    // Partial remainder. Between iterations it is always below the divisor,
    // so N bits hold it. The shifted value used for the compare is N+1 bits.
    logic [N-1:0]   rem_q;
    logic [N-1:0]   rem_d;
    // Dividend bits shift out at the top; quotient bits shift in at the bottom.
    logic [N-1:0]   dvd_q;
    logic [N-1:0]   dvd_d;
    logic [N-1:0]   dvs_q;
    logic [N-1:0]   quo_q;
    logic [N-1:0]   res_q;
    logic           busy_q;
    logic           done_q;
    logic           dz_q;

    logic [N:0]     rem_shift_s;
    logic [N:0]     diff_s;

    // One restoring iteration: shift in the next dividend bit, then trial subtract.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[N-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_q};
        // The top bit of the difference is the borrow, i.e. rem_shift < divisor.
        if (diff_s[N] == 1'b0) begin
            rem_d = diff_s[N-1:0];
            dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
            rem_d = rem_shift_s[N-1:0];
            dvd_d = {dvd_q[N-2:0], 1'b0};
        end
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {N{1'b0}};
            dvd_q   <= {N{1'b0}};
            dvs_q   <= {N{1'b0}};
            quo_q   <= {N{1'b0}};
            res_q   <= {N{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q <= A;
                        dvs_q <= B;
                        rem_q <= {N{1'b0}};
                        cnt_q <= {CW{1'b0}};
                        if (B != {N{1'b0}}) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            dz_q    <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            quo_q   <= {N{1'b1}};
                            res_q   <= A;
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(N - 1)) begin
                        quo_q   <= dvd_d;
                        res_q   <= rem_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Q        = quo_q;
    assign R        = res_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_24bit.sv
// Self-checking bench for divider_24bit: directed cases plus a random sweep
// with start held high, compared against plain integer division.
module tb_divider_24bit;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [23:0] A;
    logic [23:0] B;
    logic [23:0] Q;
    logic [23:0] R;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;

    divider_24bit #(.N(24)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done, sampling 1 time unit after each rising edge.
    task automatic wait_done(output int k, output int bc);
        k  = 0;
        bc = 0;
        while (k < 100) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) break;
            @(posedge clk); #1;
            k++;
        end
    endtask

    // One complete operation from an idle DUT, checked against integer division.
    task automatic do_op(input logic [23:0] a, input logic [23:0] b, input string tag);
        int k, bc;
        logic [23:0] eq, er;
        logic ez;
        ez = (b == 24'd0);
        eq = ez ? 24'hFFFFFF : a / b;
        er = ez ? a : a % b;
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k, bc);
        check({tag, "_done"},    64'(done),     64'd1);
        check({tag, "_latency"}, 64'(k),        ez ? 64'd0 : 64'd24);
        check({tag, "_busy"},    64'(bc),       ez ? 64'd0 : 64'd24);
        check({tag, "_q"},       64'(Q),        64'(eq));
        check({tag, "_r"},       64'(R),        64'(er));
        check({tag, "_dz"},      64'(div_zero), 64'(ez));
        @(posedge clk); #1;
        check({tag, "_pulse1"},  64'(done),     64'd0);
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_q"},    64'(Q),        64'd0);
        check({tag, "_r"},    64'(R),        64'd0);
        check({tag, "_busy"}, 64'(busy),     64'd0);
        check({tag, "_done"}, 64'(done),     64'd0);
        check({tag, "_dz"},   64'(div_zero), 64'd0);
    endtask

    initial begin
        int k, bc, p0;
        logic [23:0] ra, rb;
        rstn = 1'b0; start = 1'b0; A = 24'd0; B = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outs("reset");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(24'd213005, 24'd71, "basic");
        do_op(24'hFFFFFF, 24'd1, "max_by_1");
        do_op(24'hFFFFFF, 24'hFFFFFF, "max_by_max");
        do_op(24'd5, 24'd7, "small_by_big");
        do_op(24'd1234, 24'd0, "div0");
        do_op(24'd10, 24'd3, "after_div0");

        // start during RUN is ignored; A/B changes do not matter
        p0 = done_pulses;
        A = 24'd100; B = 24'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        A = 24'd9; B = 24'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k, bc);
        check("ignore_done",    64'(done), 64'd1);
        check("ignore_latency", 64'(k),    64'd18);
        check("ignore_q",       64'(Q),    64'd14);
        check("ignore_r",       64'(R),    64'd2);
        repeat (4) @(posedge clk);
        #1;
        check("ignore_pulses", 64'(done_pulses - p0), 64'd1);

        // Reset in the middle of an operation
        A = 24'd1000; B = 24'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        p0 = done_pulses;
        rstn = 1'b0;
        #1;
        check_zero_outs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("midreset_nodone", 64'(done_pulses - p0), 64'd0);
        do_op(24'd1000, 24'd9, "restart");

        // Random sweep with start held high
        ra = 24'($urandom());
        rb = 24'($urandom_range(1, 255));
        A = ra; B = rb; start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            wait_done(k, bc);
            check("rnd_done", 64'(done), 64'd1);
            if (i > 0) check("rnd_spacing", 64'(k + 1), 64'd26);
            check("rnd_q", 64'(Q), 64'(ra / rb));
            check("rnd_r", 64'(R), 64'(ra % rb));
            check("rnd_dz", 64'(div_zero), 64'd0);
            ra = 24'($urandom());
            if (i % 3 == 0) rb = 24'($urandom_range(1, 255));
            else            rb = 24'($urandom());
            if (rb == 24'd0) rb = 24'd1;
            A = ra; B = rb;
        end
        start = 1'b0;
        repeat (30) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
